clken_irq_gen: RTL and testbench

CLKEN_IRQ_GEN -- requirements
Module: clken_irq_gen

---
 rtl/clken_irq_gen.sv | 149 ++++++++++++++
 tb/tb_clken_irq_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clken_irq_gen.sv
// clken_irq_gen: a bank of programmable clock-enable dividers plus an
// interrupt generator. The interrupt generator counts the periods of one
// selected channel. Divisor writes are staged and take effect only at a
// period boundary, so a running period is never cut short.
module clken_irq_gen #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int DEF_DIV   = 16,
  parameter int IRQ_SRC   = NUM_CH - 1,
  parameter int IRQ_MOD   = 14,
  parameter int IRQ_AT    = 12,
  parameter int IRQ_LATCH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              irq_en,
  input  logic              irq_ack,
  output logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] lvl,
  output logic              irq,
  output logic              irq_ovr
);

  localparam int IRQ_W    = (IRQ_MOD > 1) ? $clog2(IRQ_MOD) : 1;
  // Value of irq_cnt on the advance that makes it reach IRQ_AT.
  localparam int IRQ_PREV = (IRQ_AT == 0) ? IRQ_MOD - 1 : IRQ_AT - 1;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_CH-1:0] en_vec;
  logic [NUM_CH-1:0] lvl_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] eff_div, eff_div_d;
    logic             wrap, cfg_hit, lvl_d;
    logic             en_q, lvl_q;

    // Counter, staged-divisor handover and square-wave level for the next cycle
    always_comb begin
      eff_div      = (act_div_q == '0) ? ONE : act_div_q;
      cfg_hit      = cfg_we && (cfg_ch == 3'(gi));
      wrap         = !hold && (cnt_q == eff_div - ONE);
      cnt_d        = cnt_q;
      act_div_d    = act_div_q;
      pend_div_d   = pend_div_q;
      pend_valid_d = pend_valid_q;
      if (!hold) begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
      end
      // The old pending value moves in at this wrap; a write landing in the
      // same cycle stays pending for the following wrap.
      if (wrap && pend_valid_q) begin
        act_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end
      if (cfg_hit) begin
        pend_div_d   = cfg_div;
        pend_valid_d = 1'b1;
      end
      eff_div_d = (act_div_d == '0) ? ONE : act_div_d;
      lvl_d     = (cnt_d >= (eff_div_d >> 1));
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q        <= '0;
        act_div_q    <= DIV_RST;
        pend_div_q   <= DIV_RST;
        pend_valid_q <= 1'b0;
        en_q         <= 1'b0;
        lvl_q        <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        act_div_q    <= act_div_d;
        pend_div_q   <= pend_div_d;
        pend_valid_q <= pend_valid_d;
        en_q         <= wrap;
        lvl_q        <= lvl_d;
      end
    end

    assign en_vec[gi]  = en_q;
    assign lvl_vec[gi] = lvl_q;
  end

  logic [IRQ_W-1:0] irq_cnt_q, irq_cnt_d;
  logic             irq_q, irq_d;
  logic             irq_ovr_q, irq_ovr_d;
  logic             advance, irq_event;

  // Interrupt counter advance, event detection and irq/overrun next state
  always_comb begin
    advance   = en_vec[IRQ_SRC] && !hold;
    irq_event = advance && irq_en && (irq_cnt_q == IRQ_W'(IRQ_PREV));
    irq_cnt_d = irq_cnt_q;
    irq_d     = irq_q;
    irq_ovr_d = irq_ovr_q;
    if (advance) begin
      irq_cnt_d = (irq_cnt_q == IRQ_W'(IRQ_MOD - 1)) ? '0 : irq_cnt_q + IRQ_W'(1);
    end
    if (IRQ_LATCH != 0) begin
      // Set beats acknowledge; an unacknowledged repeat event is an overrun.
      if (irq_event) begin
        irq_d = 1'b1;
        if (irq_q && !irq_ack) begin
          irq_ovr_d = 1'b1;
        end
      end else if (irq_ack) begin
        irq_d = 1'b0;
      end
    end else begin
      // Pulse lasts exactly one source period: cleared by the next advance.
      if (irq_event) begin
        irq_d = 1'b1;
      end else if (advance) begin
        irq_d = 1'b0;
      end
      irq_ovr_d = 1'b0;
    end
  end

  // Interrupt state register
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_cnt_q <= '0;
      irq_q     <= 1'b0;
      irq_ovr_q <= 1'b0;
    end else begin
      irq_cnt_q <= irq_cnt_d;
      irq_q     <= irq_d;
      irq_ovr_q <= irq_ovr_d;
    end
  end

  assign en      = en_vec;
  assign lvl     = lvl_vec;
  assign irq     = irq_q;
  assign irq_ovr = irq_ovr_q;

endmodule

// File: tb/tb_clken_irq_gen.sv
// Bench for clken_irq_gen: directed period/hold/interrupt scenarios with
// hand-derived cycle numbers, then a randomized run against a cycle model.
module tb_clken_irq_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int IRQ_MOD = 14;
  localparam int IRQ_AT  = 12;
  localparam int SRC     = NUM_CH - 1;

  logic              clk = 1'b0;
  logic              rst, hold, cfg_we, irq_en, irq_ack;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] en, lvl, en_l, lvl_l;
  logic              irq, irq_ovr, irq_l, irq_ovr_l;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt [NUM_CH];
  int m_act [NUM_CH];
  int m_pend[NUM_CH];
  bit m_pv  [NUM_CH];
  bit m_en  [NUM_CH];
  bit m_lvl [NUM_CH];
  int m_icnt;
  bit m_irq_p, m_irq_l, m_ovr_l;

  always #5 clk = ~clk;

  clken_irq_gen dut (
    .clk(clk), .rst(rst), .hold(hold), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .irq_en(irq_en), .irq_ack(irq_ack),
    .en(en), .lvl(lvl), .irq(irq), .irq_ovr(irq_ovr)
  );

  clken_irq_gen #(.IRQ_LATCH(1)) dut_lat (
    .clk(clk), .rst(rst), .hold(hold), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .irq_en(irq_en), .irq_ack(irq_ack),
    .en(en_l), .lvl(lvl_l), .irq(irq_l), .irq_ovr(irq_ovr_l)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  // Advance the model by one clock using the inputs that the DUT sees.
  task automatic model_update();
    bit adv, evt, wrapped;
    int period;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_act[i] = 16; m_pend[i] = 16;
        m_pv[i] = 0; m_en[i] = 0; m_lvl[i] = 0;
      end
      m_icnt = 0; m_irq_p = 0; m_irq_l = 0; m_ovr_l = 0;
      return;
    end
    adv = m_en[SRC] && !hold;
    evt = adv && irq_en && (((m_icnt + 1) % IRQ_MOD) == IRQ_AT);
    if (adv) m_icnt = (m_icnt + 1) % IRQ_MOD;
    if (evt) m_irq_p = 1;
    else if (adv) m_irq_p = 0;
    if (evt) begin
      if (m_irq_l && !irq_ack) m_ovr_l = 1;
      m_irq_l = 1;
    end else if (irq_ack) begin
      m_irq_l = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      period  = (m_act[i] == 0) ? 1 : m_act[i];
      wrapped = !hold && (m_cnt[i] + 1 == period);
      m_en[i] = wrapped;
      if (!hold) m_cnt[i] = (m_cnt[i] + 1) % period;
      if (wrapped && m_pv[i]) begin
        m_act[i] = m_pend[i];
        m_pv[i]  = 0;
      end
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_pend[i] = int'(cfg_div);
        m_pv[i]   = 1;
      end
      period   = (m_act[i] == 0) ? 1 : m_act[i];
      m_lvl[i] = (m_cnt[i] >= period / 2);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; hold = 0; cfg_we = 0; cfg_ch = 0; cfg_div = 0; irq_en = 0; irq_ack = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; hold = 1; cfg_we = 1; cfg_ch = 0; cfg_div = 3; irq_ack = 1;
    step();
    step();
    checks++; if (en !== 4'h0) begin errors++; $display("FAIL reset_en: got %h expected 0", en); end
    checks++; if (lvl !== 4'h0) begin errors++; $display("FAIL reset_lvl: got %h expected 0", lvl); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (irq_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", irq_ovr); end
    checks++; if (irq_l !== 1'b0 || irq_ovr_l !== 1'b0) begin
      errors++; $display("FAIL reset_latched: got irq=%b ovr=%b expected 0 0", irq_l, irq_ovr_l);
    end
    set_idle();
    $display("test_reset done");
  endtask

  task automatic test_default_period();
    logic e_en, e_lvl;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      step();
      e_en  = (k % 16 == 0);
      e_lvl = (k % 16 >= 8);
      checks++; if (en[0] !== e_en) begin errors++; $display("FAIL default_en0 cycle %0d: got %b expected %b", k, en[0], e_en); end
      checks++; if (lvl[0] !== e_lvl) begin errors++; $display("FAIL default_lvl0 cycle %0d: got %b expected %b", k, lvl[0], e_lvl); end
    end
    $display("test_default_period done");
  endtask

  task automatic test_divisor_change();
    logic [3:0] e;
    int k;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      set_idle();
      if (c == 5)  begin cfg_we = 1; cfg_ch = 1; cfg_div = 4; end
      if (c == 15) begin cfg_we = 1; cfg_ch = 2; cfg_div = 8; end
      if (c == 30) begin cfg_we = 1; cfg_ch = 5; cfg_div = 3; end
      if (c == 41) begin cfg_we = 1; cfg_ch = 1; cfg_div = 0; end
      step();
      k = c + 1;
      e[0] = (k % 16 == 0);
      e[1] = (k == 16) || (k > 16 && k < 44 && (k - 16) % 4 == 0) || (k >= 44);
      e[2] = (k == 16) || (k >= 32 && (k - 32) % 8 == 0);
      e[3] = (k % 16 == 0);
      checks++; if (en !== e) begin errors++; $display("FAIL divchange_en cycle %0d: got %h expected %h", k, en, e); end
    end
    set_idle();
    $display("test_divisor_change done");
  endtask

  task automatic test_hold();
    logic [3:0] e_en;
    logic e_lvl;
    int k, cn;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      set_idle();
      hold = (c >= 7 && c <= 16);
      step();
      k    = c + 1;
      cn   = (k <= 7) ? k : ((k <= 17) ? 7 : (k - 10) % 16);
      e_en = (k == 26) ? 4'hF : 4'h0;
      e_lvl = (cn >= 8);
      checks++; if (en !== e_en) begin errors++; $display("FAIL hold_en cycle %0d: got %h expected %h", k, en, e_en); end
      checks++; if (lvl[0] !== e_lvl) begin errors++; $display("FAIL hold_lvl0 cycle %0d: got %b expected %b", k, lvl[0], e_lvl); end
    end
    set_idle();
    $display("test_hold done");
  endtask

  task automatic test_irq_pulse();
    logic e_irq, e_irq_l, e_ovr_l;
    int k;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      set_idle();
      if (c == 0) begin cfg_we = 1; cfg_ch = 3; cfg_div = 4; end
      irq_en = (c <= 117);
      step();
      k       = c + 1;
      e_irq   = (k >= 61 && k <= 64) || (k >= 117 && k <= 120);
      e_irq_l = (k >= 61);
      e_ovr_l = (k >= 117);
      checks++; if (irq !== e_irq) begin errors++; $display("FAIL pulse_irq cycle %0d: got %b expected %b", k, irq, e_irq); end
      checks++; if (irq_ovr !== 1'b0) begin errors++; $display("FAIL pulse_ovr cycle %0d: got %b expected 0", k, irq_ovr); end
      checks++; if (irq_l !== e_irq_l) begin errors++; $display("FAIL latched_irq cycle %0d: got %b expected %b", k, irq_l, e_irq_l); end
      checks++; if (irq_ovr_l !== e_ovr_l) begin errors++; $display("FAIL latched_ovr cycle %0d: got %b expected %b", k, irq_ovr_l, e_ovr_l); end
    end
    set_idle();
    $display("test_irq_pulse done");
  endtask

  task automatic test_irq_ack();
    logic e_irq, e_irq_l;
    int k;
    do_reset();
    for (int c = 0; c < 140; c++) begin
      set_idle();
      if (c == 0) begin cfg_we = 1; cfg_ch = 3; cfg_div = 4; end
      irq_en  = 1;
      irq_ack = (c == 116) || (c == 130);
      step();
      k       = c + 1;
      e_irq   = (k >= 61 && k <= 64) || (k >= 117 && k <= 120);
      e_irq_l = (k >= 61 && k <= 130);
      checks++; if (irq_l !== e_irq_l) begin errors++; $display("FAIL ack_irq cycle %0d: got %b expected %b", k, irq_l, e_irq_l); end
      checks++; if (irq_ovr_l !== 1'b0) begin errors++; $display("FAIL ack_ovr cycle %0d: got %b expected 0", k, irq_ovr_l); end
      checks++; if (irq !== e_irq) begin errors++; $display("FAIL ack_pulse_irq cycle %0d: got %b expected %b", k, irq, e_irq); end
    end
    set_idle();
    $display("test_irq_ack done");
  endtask

  task automatic test_reset_mid();
    logic [3:0] e_en;
    int k;
    do_reset();
    for (int c = 0; c < 112; c++) begin
      set_idle();
      irq_en = 1;
      if (c == 0)  begin cfg_we = 1; cfg_ch = 3; cfg_div = 4; end
      if (c == 61) begin cfg_we = 1; cfg_ch = 0; cfg_div = 4; end
      if (c == 62) begin rst = 1; hold = 1; cfg_we = 1; cfg_ch = 0; cfg_div = 2; irq_ack = 1; end
      step();
      k = c + 1;
      if (k == 62) begin
        checks++; if (irq !== 1'b1 || irq_l !== 1'b1) begin
          errors++; $display("FAIL premid_irq: got pulse=%b latched=%b expected 1 1", irq, irq_l);
        end
      end else if (k == 63) begin
        checks++; if (en !== 4'h0 || en_l !== 4'h0) begin errors++; $display("FAIL midrst_en: got %h %h expected 0 0", en, en_l); end
        checks++; if (lvl !== 4'h0 || lvl_l !== 4'h0) begin errors++; $display("FAIL midrst_lvl: got %h %h expected 0 0", lvl, lvl_l); end
        checks++; if (irq !== 1'b0 || irq_l !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b %b expected 0 0", irq, irq_l); end
        checks++; if (irq_ovr !== 1'b0 || irq_ovr_l !== 1'b0) begin errors++; $display("FAIL midrst_ovr: got %b %b expected 0 0", irq_ovr, irq_ovr_l); end
      end else if (k > 63) begin
        e_en = ((k - 63) % 16 == 0) ? 4'hF : 4'h0;
        checks++; if (en !== e_en) begin errors++; $display("FAIL postrst_en cycle %0d: got %h expected %h", k, en, e_en); end
        checks++; if (irq !== 1'b0 || irq_l !== 1'b0) begin errors++; $display("FAIL postrst_irq cycle %0d: got %b %b expected 0 0", k, irq, irq_l); end
      end
    end
    set_idle();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [3:0] e_en, e_lvl;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom % 400 == 0);
      hold    = ($urandom % 8 == 0);
      cfg_we  = ($urandom % 5 == 0);
      cfg_ch  = 3'($urandom % 8);
      cfg_div = ($urandom % 4 == 0) ? CNT_W'($urandom % 40) : CNT_W'($urandom % 10);
      irq_en  = ($urandom % 8 != 0);
      irq_ack = ($urandom % 6 == 0);
      step();
      for (int i = 0; i < NUM_CH; i++) begin
        e_en[i]  = m_en[i];
        e_lvl[i] = m_lvl[i];
      end
      checks++; if (en !== e_en || en_l !== e_en) begin errors++; $display("FAIL rand_en step %0d: got %h %h expected %h", n, en, en_l, e_en); end
      checks++; if (lvl !== e_lvl || lvl_l !== e_lvl) begin errors++; $display("FAIL rand_lvl step %0d: got %h %h expected %h", n, lvl, lvl_l, e_lvl); end
      checks++; if (irq !== m_irq_p || irq_ovr !== 1'b0) begin
        errors++; $display("FAIL rand_pulse step %0d: got irq=%b ovr=%b expected %b 0", n, irq, irq_ovr, m_irq_p);
      end
      checks++; if (irq_l !== m_irq_l || irq_ovr_l !== m_ovr_l) begin
        errors++; $display("FAIL rand_latched step %0d: got irq=%b ovr=%b expected %b %b", n, irq_l, irq_ovr_l, m_irq_l, m_ovr_l);
      end
    end
    set_idle();
    $display("test_random done");
  endtask

  initial begin
    set_idle();
    test_reset();
    test_default_period();
    test_divisor_change();
    test_hold();
    test_irq_pulse();
    test_irq_ack();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
